// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helpers and the sweep FSM state type.
// Hash words are packed with word 0 (A / H0) in the least significant bits.
package sha256_pkg;

   typedef logic [7:0][31:0]  hash_t;
   typedef logic [15:0][31:0] win_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMP1,
      ST_FIN1,
      ST_COMP2,
      ST_CHECK
   } sweep_state_t;

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam hash_t IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Window holds W[t..t+15]; this yields W[t+16].
   function automatic logic [31:0] next_w(input win_t w);
      return ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
   endfunction

   function automatic hash_t sha_round(input hash_t s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] t1;
      logic [31:0] t2;
      hash_t       r;
      t1   = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
      t2   = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      r[0] = t1 + t2;
      r[1] = s[0];
      r[2] = s[1];
      r[3] = s[2];
      r[4] = s[3] + t1;
      r[5] = s[4];
      r[6] = s[5];
      r[7] = s[6];
      return r;
   endfunction

   function automatic hash_t hash_add(input hash_t a, input hash_t b);
      hash_t r;
      for (int i = 0; i < 8; i++) begin
         r[i] = a[i] + b[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/sha256_round_stage.sv
// R chained SHA-256 rounds with a 16-word sliding schedule window; purely combinational.
// Zero latency, no flow control: the caller registers state and window every cycle it advances.
module sha256_round_stage
   import sha256_pkg::*;
#(
   parameter int R = 1
) (
   input  logic [255:0] state_in,
   input  logic [511:0] win_in,
   input  logic [5:0]   round,
   output logic [255:0] state_out,
   output logic [511:0] win_out
);

   hash_t s;
   win_t  w;

   always_comb begin
      s = state_in;
      w = win_in;
      for (int r = 0; r < R; r++) begin
         s = sha_round(s, K[round + 6'(r)], w[0]);
         w = {next_w(w), w[15:1]};
      end
      state_out = s;
      win_out   = w;
   end

endmodule

// File: rtl/sha256d_nonce_sweep.sv
// Double-SHA-256 nonce sweep: one digest per 2*(64/R)+3 cycles, hit strobe on the CHECK edge.
// No backpressure: start is taken only in IDLE, abort wins over everything but reset.
module sha256d_nonce_sweep
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit STOP_ON_HIT      = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         abort,
   input  logic [255:0] pre_hash,
   input  logic [95:0]  tail,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  nonce_count,
   input  logic [31:0]  target,
   output logic         busy,
   output logic         done,
   output logic         found_valid,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_hash,
   output logic [31:0]  hit_count
);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [5:0] RSTEP = 6'(ROUNDS_PER_CYCLE);
   localparam logic [5:0] RLAST = 6'(64 - ROUNDS_PER_CYCLE);

   sweep_state_t     state;
   hash_t            st;
   hash_t            st_nx;
   hash_t            mid;
   hash_t            digest;
   win_t             win;
   win_t             win_nx;
   logic [2:0][31:0] tail_q;
   logic [31:0]      target_q;
   logic [31:0]      nonce;
   logic [31:0]      remaining;
   logic [5:0]       rnd;
   logic             hit;

   sha256_round_stage #(
      .R (ROUNDS_PER_CYCLE)
   ) u_stage (
      .state_in  (st),
      .win_in    (win),
      .round     (rnd),
      .state_out (st_nx),
      .win_out   (win_nx)
   );

   assign digest = hash_add(st, IV);
   assign hit    = (digest[7] <= target_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b1;
         found_valid <= 1'b0;
         found_nonce <= '0;
         found_hash  <= '0;
         hit_count   <= '0;
         st          <= '0;
         mid         <= '0;
         win         <= '0;
         tail_q      <= '0;
         target_q    <= '0;
         nonce       <= '0;
         remaining   <= '0;
         rnd         <= '0;
      end else begin
         found_valid <= 1'b0;
         if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     mid       <= pre_hash;
                     tail_q    <= tail;
                     target_q  <= target;
                     nonce     <= nonce_start;
                     remaining <= nonce_count;
                     hit_count <= '0;
                     if (nonce_count != '0) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                     end
                  end
               end
               // Second block of the 80-byte header: tail, nonce, padding, 640-bit length.
               ST_LOAD: begin
                  st    <= mid;
                  win   <= {32'd640, 320'd0, 32'h80000000, nonce, tail_q};
                  rnd   <= '0;
                  state <= ST_COMP1;
               end
               ST_COMP1, ST_COMP2: begin
                  st  <= st_nx;
                  win <= win_nx;
                  rnd <= rnd + RSTEP;
                  if (rnd == RLAST) begin
                     state <= (state == ST_COMP1) ? ST_FIN1 : ST_CHECK;
                  end
               end
               // First digest becomes the single padded block of the outer hash.
               ST_FIN1: begin
                  win   <= {32'd256, 192'd0, 32'h80000000, hash_add(st, mid)};
                  st    <= IV;
                  rnd   <= '0;
                  state <= ST_COMP2;
               end
               ST_CHECK: begin
                  if (hit) begin
                     found_valid <= 1'b1;
                     found_nonce <= nonce;
                     found_hash  <= digest;
                     if (hit_count != '1) begin
                        hit_count <= hit_count + 32'd1;
                     end
                  end
                  remaining <= remaining - 32'd1;
                  nonce     <= nonce + 32'd1;
                  if (remaining == 32'd1 || (hit && STOP_ON_HIT)) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_LOAD;
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256d_nonce_sweep.sv
// Directed bench for sha256d_nonce_sweep around the Bitcoin genesis header, three R/STOP_ON_HIT variants.
// Expected hits come from a plain SHA-256 reference model and are queued when each sweep is started.
module tb_sha256d_nonce_sweep;

   localparam int C1 = 2 * 64 + 3;
   localparam int C2 = 2 * 32 + 3;
   localparam int C4 = 2 * 16 + 3;
   localparam logic [95:0] TAIL = {32'hffff001d, 32'h29ab5f49, 32'h4b1e5e4a};
   localparam logic [511:0] BLK1 = {32'h3a9fb8aa, 32'h888a5132, 32'h7fc81bc3, 32'h67768f61,
                                    32'h7ac72c3e, 32'h7a7b12b2, 32'h3ba3edfd, 256'd0, 32'h01000000};

   typedef struct {
      logic [31:0]  nonce;
      logic [255:0] hash;
      logic [31:0]  hits;
      int           lat;
   } exp_t;

   logic              clk;
   logic              reset_n;
   logic [2:0]        start;
   logic [2:0]        abort;
   logic [255:0]      pre_hash;
   logic [95:0]       tail;
   logic [31:0]       nonce_start;
   logic [31:0]       nonce_count;
   logic [31:0]       target;
   logic [2:0]        busy;
   logic [2:0]        done;
   logic [2:0]        fv;
   logic [2:0][31:0]  fn;
   logic [2:0][255:0] fh;
   logic [2:0][31:0]  hc;

   int           cyc = 0;
   int           t0 = 0;
   int           n_assert = 0;
   int           n_fail = 0;
   logic [255:0] mid;
   logic [255:0] genesis;
   exp_t         sb[$];

   sha256d_nonce_sweep #(.ROUNDS_PER_CYCLE(1), .STOP_ON_HIT(1'b1)) u_r1 (
      .clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort[0]), .pre_hash(pre_hash), .tail(tail),
      .nonce_start(nonce_start), .nonce_count(nonce_count), .target(target), .busy(busy[0]), .done(done[0]),
      .found_valid(fv[0]), .found_nonce(fn[0]), .found_hash(fh[0]), .hit_count(hc[0]));

   sha256d_nonce_sweep #(.ROUNDS_PER_CYCLE(2), .STOP_ON_HIT(1'b1)) u_r2 (
      .clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort[1]), .pre_hash(pre_hash), .tail(tail),
      .nonce_start(nonce_start), .nonce_count(nonce_count), .target(target), .busy(busy[1]), .done(done[1]),
      .found_valid(fv[1]), .found_nonce(fn[1]), .found_hash(fh[1]), .hit_count(hc[1]));

   sha256d_nonce_sweep #(.ROUNDS_PER_CYCLE(4), .STOP_ON_HIT(1'b0)) u_r4 (
      .clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort[2]), .pre_hash(pre_hash), .tail(tail),
      .nonce_start(nonce_start), .nonce_count(nonce_count), .target(target), .busy(busy[2]), .done(done[2]),
      .found_valid(fv[2]), .found_nonce(fn[2]), .found_hash(fh[2]), .hit_count(hc[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] s, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      {h, g, f, e, d, c, b, a} = s;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + sha256_pkg::K[i[5:0]] + w[i];
         t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h + s[255:224], g + s[223:192], f + s[191:160], e + s[159:128],
              d + s[127:96], c + s[95:64], b + s[63:32], a + s[31:0]};
   endfunction

   function automatic logic [255:0] dhash(input logic [255:0] m, input logic [95:0] t, input logic [31:0] n);
      logic [255:0] h1;
      h1 = compress(m, {32'd640, 320'd0, 32'h80000000, n, t});
      return compress(sha256_pkg::IV, {32'd256, 192'd0, 32'h80000000, h1});
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_hit(input logic [31:0] n, input logic [31:0] hits, input int lat);
      exp_t e;
      e.nonce = n;
      e.hash  = dhash(mid, TAIL, n);
      e.hits  = hits;
      e.lat   = lat;
      sb.push_back(e);
   endtask

   task automatic kick(input logic [1:0] i, input logic [31:0] ns, input logic [31:0] cnt, input logic [31:0] tgt);
      @(negedge clk);
      nonce_start = ns;
      nonce_count = cnt;
      target      = tgt;
      start[i]    = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      t0       = cyc;
   endtask

   task automatic check_strobe(input logic [1:0] i, input int budget, input string tag);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge clk);
         ok = fv[i];
      end
      chk({tag, "_seen"}, 256'(ok), 256'(1'b1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (ok) begin
            chk({tag, "_nonce"}, 256'(fn[i]), 256'(e.nonce));
            chk({tag, "_hash"}, fh[i], e.hash);
            chk({tag, "_hits"}, 256'(hc[i]), 256'(e.hits));
            chk({tag, "_lat"}, 256'(cyc - t0), 256'(e.lat));
         end
      end
   endtask

   task automatic no_strobe(input logic [1:0] i, input int ncyc, input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         seen = seen | fv[i];
      end
      chk(tag, 256'(seen), 256'(1'b0));
   endtask

   initial begin
      bit seen_busy;
      reset_n     = 1'b0;
      start       = '0;
      abort       = '0;
      nonce_start = '0;
      nonce_count = '0;
      target      = '0;
      mid         = compress(sha256_pkg::IV, BLK1);
      genesis     = dhash(mid, TAIL, 32'h1DAC2B7C);
      pre_hash    = mid;
      tail        = TAIL;

      repeat (3) @(negedge clk);
      chk("rst_done", 256'(done[0]), 256'(1'b1));
      chk("rst_busy", 256'(busy[0]), 256'(1'b0));
      chk("rst_valid", 256'(fv[0]), 256'(1'b0));
      chk("rst_nonce", 256'(fn[0]), 256'(0));
      chk("rst_hash", fh[0], 256'(0));
      chk("rst_hits", 256'(hc[0]), 256'(0));
      reset_n = 1'b1;

      // Genesis, R=1, stop on first hit at the third nonce.
      expect_hit(32'h1DAC2B7C, 32'd1, 3 * C1);
      kick(2'd0, 32'h1DAC2B7A, 32'd4, 32'd0);
      check_strobe(2'd0, 3 * C1 + 20, "r1_gen");
      chk("r1_gen_h0", 256'(fh[0][31:0]), 256'(32'h6FE28C0A));
      chk("r1_gen_h7", 256'(fh[0][255:224]), 256'(32'h0));
      @(negedge clk);
      chk("r1_strobe_len", 256'(fv[0]), 256'(1'b0));
      chk("r1_done", 256'(done[0]), 256'(1'b1));
      no_strobe(2'd0, 20, "r1_after_stop");

      // start and abort together: nothing latched, hit_count keeps 1.
      @(negedge clk);
      nonce_start = 32'h0;
      nonce_count = 32'd4;
      target      = 32'hFFFFFFFF;
      start[0]    = 1'b1;
      abort[0]    = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("start_abort_busy", 256'(busy[0]), 256'(1'b0));
      chk("start_abort_hits", 256'(hc[0]), 256'(32'd1));

      // Zero-length sweep clears hit_count and never raises busy.
      kick(2'd0, 32'h1DAC2B7A, 32'd0, 32'd0);
      seen_busy = busy[0];
      repeat (5) begin
         @(negedge clk);
         seen_busy = seen_busy | busy[0];
      end
      chk("cnt0_busy", 256'(seen_busy), 256'(1'b0));
      chk("cnt0_hits", 256'(hc[0]), 256'(0));

      // Abort in COMP2 of a nonce that would hit.
      kick(2'd0, 32'h1DAC2B7A, 32'd4, 32'hFFFFFFFF);
      repeat (99) @(negedge clk);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("abort_busy", 256'(busy[0]), 256'(1'b0));
      chk("abort_done", 256'(done[0]), 256'(1'b1));
      no_strobe(2'd0, 200, "abort_no_strobe");
      chk("abort_nonce_held", 256'(fn[0]), 256'(32'h1DAC2B7C));
      chk("abort_hash_held", fh[0], genesis);
      chk("abort_hits_held", 256'(hc[0]), 256'(0));

      // Genesis, R=2, with a start pulse while busy that must be ignored.
      expect_hit(32'h1DAC2B7C, 32'd1, 3 * C2);
      kick(2'd1, 32'h1DAC2B7A, 32'd4, 32'd0);
      repeat (30) @(negedge clk);
      nonce_start = 32'h0;
      nonce_count = 32'd1;
      target      = 32'hFFFFFFFF;
      start[1]    = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      check_strobe(2'd1, 3 * C2, "r2_gen");
      @(negedge clk);
      chk("r2_done", 256'(done[1]), 256'(1'b1));

      // Genesis, R=4, last nonce is the hit.
      expect_hit(32'h1DAC2B7C, 32'd1, 3 * C4);
      kick(2'd2, 32'h1DAC2B7A, 32'd3, 32'd0);
      check_strobe(2'd2, 3 * C4 + 20, "r4_gen");
      @(negedge clk);
      chk("r4_done", 256'(done[2]), 256'(1'b1));

      // Every nonce hits, sweep continues.
      expect_hit(32'h1DAC2B7A, 32'd1, C4);
      expect_hit(32'h1DAC2B7B, 32'd2, 2 * C4);
      expect_hit(32'h1DAC2B7C, 32'd3, 3 * C4);
      kick(2'd2, 32'h1DAC2B7A, 32'd3, 32'hFFFFFFFF);
      check_strobe(2'd2, C4 + 20, "all_hit0");
      check_strobe(2'd2, C4 + 20, "all_hit1");
      check_strobe(2'd2, C4 + 20, "all_hit2");
      @(negedge clk);
      chk("all_hit_done", 256'(done[2]), 256'(1'b1));

      // Nonce wraps from all-ones to zero.
      expect_hit(32'hFFFFFFFF, 32'd1, C4);
      expect_hit(32'h00000000, 32'd2, 2 * C4);
      kick(2'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
      check_strobe(2'd2, C4 + 20, "wrap0");
      check_strobe(2'd2, C4 + 20, "wrap1");

      // Asynchronous reset mid-sweep, checked before the next clock edge.
      kick(2'd2, 32'h1DAC2B7A, 32'd3, 32'hFFFFFFFF);
      repeat (50) @(negedge clk);
      chk("pre_rst_hits", 256'(hc[2]), 256'(32'd1));
      #3 reset_n = 1'b0;
      #1;
      chk("arst_busy", 256'(busy[2]), 256'(1'b0));
      chk("arst_done", 256'(done[2]), 256'(1'b1));
      chk("arst_valid", 256'(fv[2]), 256'(1'b0));
      chk("arst_nonce", 256'(fn[2]), 256'(0));
      chk("arst_hash", fh[2], 256'(0));
      chk("arst_hits", 256'(hc[2]), 256'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      chk("scoreboard_empty", 256'(sb.size()), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
